cta_warp_launcher: RTL and testbench
====================================

Name: cta_warp_launcher

Overview:
- Per-core consumer of the kernel management unit (KMU) task interface.
- Accepts one CTA assignment at a time and spawns that CTA's warps into the core's warp scheduler over a valid/ready handshake.
- Tracks warp completion and re-asserts core_ready only after every warp of the current CTA has retired.
- Holds the current CTA coordinates, id and kernel param in registers for the core's CSR unit.

Parameters:
NUM_WARPS, 4, hardware warps per core
NUM_THREADS, 4, threads per warp
NW_BITS, max($clog2(NUM_WARPS),1), warp id width

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse; enables launching (sticky until reset)
core_ready  out  1  to KMU; high = task on task_* is consumed this cycle
task_start_pc  in  32  kernel entry PC
task_param  in  32  kernel argument pointer
task_cta_x  in  32  CTA x; 32'hFFFF_FFFF = grid exhausted, no task
task_cta_y  in  32  CTA y
task_cta_z  in  32  CTA z
task_cta_id  in  32  linear CTA id
task_num_warps  in  32  warps in this CTA
task_last_tmask  in  NUM_THREADS  thread mask of the final warp
spawn_valid  out  1  warp spawn request
spawn_ready  in  1  scheduler accepts spawn
spawn_wid  out  NW_BITS  warp id to start
spawn_pc  out  32  start PC
spawn_tmask  out  NUM_THREADS  thread mask
warp_done_valid  in  1  a warp executed its terminating instruction
warp_done_wid  in  NW_BITS  id of that warp
cta_x, cta_y, cta_z, cta_id, cta_param  out  32 each  current CTA state for the CSR unit
cta_done  out  1  one-cycle pulse when the CTA fully retires
err_task  out  1  one-cycle pulse: task_num_warps is 0 or greater than NUM_WARPS; task dropped

Behaviour:
- Reset: state=IDLE, enabled=0, active_mask=0, wid_cnt=0. All outputs are 0; core_ready=0.
- enabled:
  - Set on start.
  - Cleared only by reset.
- core_ready = enabled && state==IDLE. This output is combinational from registers only, with no path from task_* inputs.
- The KMU advances its counters on every cycle core_ready=1, so a task is consumed unconditionally in such a cycle.
- IDLE with core_ready=1:
  - task_cta_x==all-ones: stay IDLE, latch nothing.
  - num_warps==0 or num_warps>NUM_WARPS: pulse err_task next cycle, stay IDLE.
  - Otherwise latch pc, param, cta_x/y/z/id, num_warps, last_tmask; wid_cnt=0; go to SPAWN.
- SPAWN:
  - spawn_valid=1, spawn_wid=wid_cnt, spawn_pc=latched pc.
  - spawn_tmask = last_tmask if wid_cnt==num_warps-1, else all ones.
  - Outputs stay stable while spawn_ready=0.
  - On handshake: set active_mask[wid_cnt] and increment wid_cnt. On the handshake of the last warp, go to RUN.
- warp_done, accepted in any state:
  - Clear active_mask[warp_done_wid].
  - If that bit was already 0, ignore it. Simulation assertion fires.
  - Same-cycle spawn handshake and done on the same wid: set wins; simulation assertion fires.
- RUN: when active_mask==0 (evaluated on the registered value), go to DONE.
- DONE: cta_done=1 for one cycle, go to IDLE. core_ready is first high in the cycle after DONE.
- Latency:
  - Task consumed to first spawn_valid: 1 cycle.
  - Last warp_done to cta_done: 2 cycles (mask update, then RUN→DONE).
  - cta_done to core_ready: 1 cycle.
- cta_* CSR outputs hold the last latched CTA until the next task is latched.
- Reset mid-operation returns to IDLE with enabled=0. In-flight warps are the scheduler's responsibility.

Decomposition:
- Shared package VX_gpu_pkg additions:
  - cta_launch_state_e {IDLE, SPAWN, RUN, DONE}.
  - CTA_INVALID_X = 32'hFFFF_FFFF.
  - cta_task_t: struct of the task_* fields.
- No sub-module. A single FSM plus active_mask register.

Test Plan:
- start pulse, then task{pc=0x80000000, cta=(0,0,1), id=1, num_warps=3, last_tmask=4'b0011}, spawn_ready=1 → core_ready drops next cycle; spawns wid 0,1,2 on consecutive cycles with tmasks 1111, 1111, 0011, all with pc 0x80000000; cta_z=1, cta_id=1.
- spawn_ready low for 5 cycles during SPAWN → spawn_valid held; wid/pc/tmask stable; no warp skipped.
- After 3 spawns, done wid 2, 0, 1 on separated cycles → cta_done pulses exactly 2 cycles after the wid-1 done; core_ready=1 one cycle after that.
- Task with num_warps=5 (NUM_WARPS=4), and separately num_warps=0 → err_task pulse each time, no spawn_valid, core_ready stays 1.
- task_cta_x=0xFFFFFFFF with core_ready=1 → no latch, no spawn, cta_* unchanged.
- Reset asserted in RUN with active_mask=4'b0101 → next cycle state IDLE, mask 0, core_ready=0 until start.

Source files
------------

// File: rtl/cta_warp_launcher_pkg.sv
// Shared types for the per-core CTA launcher: FSM state encoding, the
// "grid exhausted" sentinel and the latched task record.
package cta_warp_launcher_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SPAWN,
    RUN,
    DONE
  } cta_launch_state_e;

  localparam logic [31:0] CTA_INVALID_X = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] start_pc;
    logic [31:0] param;
    logic [31:0] cta_x;
    logic [31:0] cta_y;
    logic [31:0] cta_z;
    logic [31:0] cta_id;
    logic [31:0] num_warps;
  } cta_task_t;

endpackage

// File: rtl/cta_warp_launcher.sv
// Consumes one KMU CTA task at a time, spawns its warps into the scheduler,
// and waits for every warp to retire before asking for the next task.
module cta_warp_launcher
  import cta_warp_launcher_pkg::*;
#(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   core_ready,
  input  logic [31:0]            task_start_pc,
  input  logic [31:0]            task_param,
  input  logic [31:0]            task_cta_x,
  input  logic [31:0]            task_cta_y,
  input  logic [31:0]            task_cta_z,
  input  logic [31:0]            task_cta_id,
  input  logic [31:0]            task_num_warps,
  input  logic [NUM_THREADS-1:0] task_last_tmask,
  output logic                   spawn_valid,
  input  logic                   spawn_ready,
  output logic [NW_BITS-1:0]     spawn_wid,
  output logic [31:0]            spawn_pc,
  output logic [NUM_THREADS-1:0] spawn_tmask,
  input  logic                   warp_done_valid,
  input  logic [NW_BITS-1:0]     warp_done_wid,
  output logic [31:0]            cta_x,
  output logic [31:0]            cta_y,
  output logic [31:0]            cta_z,
  output logic [31:0]            cta_id,
  output logic [31:0]            cta_param,
  output logic                   cta_done,
  output logic                   err_task
);

  localparam logic [NW_BITS-1:0] WID_ONE = NW_BITS'(1);

  cta_launch_state_e      r_state;
  logic                   r_enabled;
  logic [NUM_WARPS-1:0]   r_active_mask;
  logic [NW_BITS-1:0]     r_wid_cnt;
  cta_task_t              r_task;
  logic [NUM_THREADS-1:0] r_last_tmask;
  logic                   r_err_task;

  logic                   w_spawning;
  logic                   w_last;
  logic                   w_task_ok;
  logic [NUM_WARPS-1:0]   w_set;
  logic [NUM_WARPS-1:0]   w_clr;

  assign w_spawning = (r_state == SPAWN);
  assign w_last     = ({{(32-NW_BITS){1'b0}}, r_wid_cnt} == (r_task.num_warps - 32'd1));
  assign w_task_ok  = (task_num_warps != 32'd0) && (task_num_warps <= 32'(NUM_WARPS));

  assign core_ready  = r_enabled && (r_state == IDLE);
  assign spawn_valid = w_spawning;
  assign spawn_wid   = w_spawning ? r_wid_cnt : '0;
  assign spawn_pc    = w_spawning ? r_task.start_pc : '0;
  assign spawn_tmask = w_spawning ? (w_last ? r_last_tmask : '1) : '0;
  assign cta_done    = (r_state == DONE);
  assign err_task    = r_err_task;

  assign cta_x     = r_task.cta_x;
  assign cta_y     = r_task.cta_y;
  assign cta_z     = r_task.cta_z;
  assign cta_id    = r_task.cta_id;
  assign cta_param = r_task.param;

  // A spawn and a done on the same wid in one cycle resolve to "set".
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (spawn_valid && spawn_ready) w_set[r_wid_cnt] = 1'b1;
    if (warp_done_valid)            w_clr[warp_done_wid] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_enabled     <= 1'b0;
      r_active_mask <= '0;
      r_wid_cnt     <= '0;
      r_task        <= '0;
      r_last_tmask  <= '0;
      r_err_task    <= 1'b0;
    end else begin
      assert (!(warp_done_valid && !r_active_mask[warp_done_wid]));
      assert ((w_set & w_clr) == '0);
      r_err_task    <= 1'b0;
      r_active_mask <= (r_active_mask & ~w_clr) | w_set;
      if (start) r_enabled <= 1'b1;
      case (r_state)
        IDLE: begin
          if (core_ready && (task_cta_x != CTA_INVALID_X)) begin
            if (!w_task_ok) begin
              r_err_task <= 1'b1;
            end else begin
              r_task.start_pc  <= task_start_pc;
              r_task.param     <= task_param;
              r_task.cta_x     <= task_cta_x;
              r_task.cta_y     <= task_cta_y;
              r_task.cta_z     <= task_cta_z;
              r_task.cta_id    <= task_cta_id;
              r_task.num_warps <= task_num_warps;
              r_last_tmask     <= task_last_tmask;
              r_wid_cnt        <= '0;
              r_state          <= SPAWN;
            end
          end
        end
        SPAWN: begin
          if (spawn_ready) begin
            r_wid_cnt <= r_wid_cnt + WID_ONE;
            if (w_last) r_state <= RUN;
          end
        end
        RUN:     if (r_active_mask == '0) r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cta_warp_launcher.sv
// Randomized self-checking bench for cta_warp_launcher; expectations come from
// a task-level model (spawn list per CTA, CSR shadow, fixed latencies).
module tb_cta_warp_launcher;

  localparam int NW = 4;
  localparam int NT = 4;

  logic          clk = 1'b0;
  logic          reset, start, core_ready;
  logic [31:0]   task_start_pc, task_param, task_cta_x, task_cta_y, task_cta_z;
  logic [31:0]   task_cta_id, task_num_warps;
  logic [NT-1:0] task_last_tmask;
  logic          spawn_valid, spawn_ready;
  logic [1:0]    spawn_wid;
  logic [31:0]   spawn_pc;
  logic [NT-1:0] spawn_tmask;
  logic          warp_done_valid;
  logic [1:0]    warp_done_wid;
  logic [31:0]   cta_x, cta_y, cta_z, cta_id, cta_param;
  logic          cta_done, err_task;

  int n_checks = 0;
  int n_fail   = 0;
  logic [159:0] exp_csr;

  cta_warp_launcher #(.NUM_WARPS(NW), .NUM_THREADS(NT)) dut (
    .clk(clk), .reset(reset), .start(start), .core_ready(core_ready),
    .task_start_pc(task_start_pc), .task_param(task_param),
    .task_cta_x(task_cta_x), .task_cta_y(task_cta_y), .task_cta_z(task_cta_z),
    .task_cta_id(task_cta_id), .task_num_warps(task_num_warps),
    .task_last_tmask(task_last_tmask),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_wid(spawn_wid),
    .spawn_pc(spawn_pc), .spawn_tmask(spawn_tmask),
    .warp_done_valid(warp_done_valid), .warp_done_wid(warp_done_wid),
    .cta_x(cta_x), .cta_y(cta_y), .cta_z(cta_z), .cta_id(cta_id),
    .cta_param(cta_param), .cta_done(cta_done), .err_task(err_task)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 0; spawn_ready = 0; warp_done_valid = 0; warp_done_wid = 0;
    task_cta_x = '1; task_start_pc = 0; task_param = 0; task_cta_y = 0;
    task_cta_z = 0; task_cta_id = 0; task_num_warps = 0; task_last_tmask = 0;
    reset = 1; step(); step(); reset = 0;
    exp_csr = '0;
  endtask

  task automatic pulse_start();
    start = 1; step(); start = 0;
  endtask

  task automatic check_csr(input string name);
    n_checks++;
    if ({cta_x, cta_y, cta_z, cta_id, cta_param} !== exp_csr) begin
      n_fail++;
      $display("FAIL %s csr got=%h exp=%h", name, {cta_x, cta_y, cta_z, cta_id, cta_param}, exp_csr);
    end
  endtask

  // Waits for core_ready, presents one task for the consuming cycle, returns after it.
  task automatic present(input logic [31:0] pc, prm, x, y, z, id, n, input logic [NT-1:0] tm);
    for (int c = 0; c < 50 && !core_ready; c++) step();
    n_checks++;
    if (core_ready !== 1'b1) begin n_fail++; $display("FAIL wait_core_ready got=%b exp=1", core_ready); end
    task_start_pc = pc; task_param = prm; task_cta_x = x; task_cta_y = y; task_cta_z = z;
    task_cta_id = id; task_num_warps = n; task_last_tmask = tm;
    step();
    task_cta_x = '1;
    if (x != 32'hFFFF_FFFF && n >= 1 && n <= NW) exp_csr = {x, y, z, id, prm};
  endtask

  // mode 0: always ready, 1: random ready, 2: hold ready low 5 cycles on warp 1.
  task automatic collect_spawns(input string name, input int n, input logic [31:0] pc,
                                input logic [NT-1:0] last, input int mode);
    int i = 0;
    int stall = 0;
    bit hold = 0;
    logic [37:0] prev = '0;
    logic [NT-1:0] etm;
    for (int c = 0; c < 300 && i < n; c++) begin
      if (hold) begin
        n_checks++;
        if ({spawn_valid, spawn_wid, spawn_pc, spawn_tmask} !== {1'b1, prev}) begin
          n_fail++;
          $display("FAIL %s_stable got=%h exp=%h", name, {spawn_valid, spawn_wid, spawn_pc, spawn_tmask}, {1'b1, prev});
        end
      end
      case (mode)
        0: spawn_ready = 1;
        1: spawn_ready = 1'($urandom_range(1, 0));
        default: begin
          spawn_ready = !(i == 1 && stall < 5);
          if (i == 1 && spawn_valid) stall++;
        end
      endcase
      hold = spawn_valid && !spawn_ready;
      prev = {spawn_wid, spawn_pc, spawn_tmask};
      if (spawn_valid && spawn_ready) begin
        etm = (i == n - 1) ? last : '1;
        n_checks++;
        if ({spawn_wid, spawn_pc, spawn_tmask} !== {2'(i), pc, etm}) begin
          n_fail++;
          $display("FAIL %s_spawn%0d got=%h exp=%h", name, i, {spawn_wid, spawn_pc, spawn_tmask}, {2'(i), pc, etm});
        end
        i++;
      end
      step();
    end
    spawn_ready = 0;
    n_checks++;
    if (i != n || spawn_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_count got=%0d valid=%b exp=%0d valid=0", name, i, spawn_valid, n);
    end
  endtask

  task automatic send_done(input int wid);
    warp_done_valid = 1; warp_done_wid = 2'(wid); step(); warp_done_valid = 0;
  endtask

  // Retires warps in the given order; checks the 2-cycle cta_done and 1-cycle core_ready latency.
  task automatic retire(input string name, input int ord[$]);
    for (int k = 0; k < ord.size(); k++) begin
      send_done(ord[k]);
      if (k != ord.size() - 1) begin
        n_checks++;
        if (cta_done !== 1'b0) begin n_fail++; $display("FAIL %s_early_done got=%b exp=0", name, cta_done); end
        step();
      end
    end
    n_checks++;
    if (cta_done !== 1'b0) begin n_fail++; $display("FAIL %s_done_t1 got=%b exp=0", name, cta_done); end
    step();
    n_checks++;
    if ({cta_done, core_ready} !== 2'b10) begin n_fail++; $display("FAIL %s_done_t2 got=%b exp=10", name, {cta_done, core_ready}); end
    step();
    n_checks++;
    if ({cta_done, core_ready} !== 2'b01) begin n_fail++; $display("FAIL %s_ready_after got=%b exp=01", name, {cta_done, core_ready}); end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({core_ready, spawn_valid, spawn_wid, spawn_pc, spawn_tmask, cta_done, err_task} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0", {core_ready, spawn_valid, spawn_wid, spawn_pc, spawn_tmask, cta_done, err_task});
    end
    check_csr("reset");
    step(); step();
    n_checks++;
    if (core_ready !== 1'b0) begin n_fail++; $display("FAIL reset_no_start got=%b exp=0", core_ready); end
  endtask

  task automatic test_basic();
    int ord[$] = '{2, 0, 1};
    pulse_start();
    n_checks++;
    if (core_ready !== 1'b1) begin n_fail++; $display("FAIL start_ready got=%b exp=1", core_ready); end
    present(32'h8000_0000, 32'h1234, 0, 0, 1, 1, 3, 4'b0011);
    n_checks++;
    if ({core_ready, spawn_valid} !== 2'b01) begin n_fail++; $display("FAIL basic_latency got=%b exp=01", {core_ready, spawn_valid}); end
    check_csr("basic");
    collect_spawns("basic", 3, 32'h8000_0000, 4'b0011, 0);
    retire("basic", ord);
    check_csr("basic_hold");
  endtask

  task automatic test_stall();
    int ord[$] = '{0, 1, 2, 3};
    present(32'h0000_4000, 32'hBEEF, 7, 8, 9, 10, 4, 4'b1000);
    collect_spawns("stall", 4, 32'h0000_4000, 4'b1000, 2);
    retire("stall", ord);
  endtask

  task automatic test_err();
    logic [31:0] bad[3];
    bad[0] = 5; bad[1] = 0; bad[2] = $urandom_range(1000, 6);
    for (int k = 0; k < 3; k++) begin
      present($urandom, $urandom, 3, 4, 5, 6, bad[k], 4'hF);
      n_checks++;
      if ({err_task, spawn_valid, core_ready} !== 3'b101) begin
        n_fail++;
        $display("FAIL err_pulse%0d got=%b exp=101", k, {err_task, spawn_valid, core_ready});
      end
      step();
      n_checks++;
      if ({err_task, spawn_valid, core_ready} !== 3'b001) begin
        n_fail++;
        $display("FAIL err_clear%0d got=%b exp=001", k, {err_task, spawn_valid, core_ready});
      end
      check_csr("err");
    end
  endtask

  task automatic test_invalid();
    present($urandom, $urandom, 32'hFFFF_FFFF, $urandom, $urandom, $urandom, 2, 4'h1);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({spawn_valid, err_task, core_ready} !== 3'b001) begin
        n_fail++;
        $display("FAIL invalid_c%0d got=%b exp=001", c, {spawn_valid, err_task, core_ready});
      end
      step();
    end
    check_csr("invalid");
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 8; t++) begin
      int n = $urandom_range(NW, 1);
      logic [31:0] pc = $urandom & 32'hFFFF_FFFC;
      logic [NT-1:0] tm = NT'($urandom_range(15, 1));
      int ord[$];
      for (int i = 0; i < n; i++) ord.push_back(i);
      for (int i = n - 1; i > 0; i--) begin
        int j = $urandom_range(i, 0);
        int tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
      end
      present(pc, $urandom, $urandom_range(1000, 0), $urandom, $urandom, t + 100, n, tm);
      check_csr("b2b");
      collect_spawns("b2b", n, pc, tm, 1);
      retire("b2b", ord);
    end
  endtask

  task automatic test_reset_mid();
    int ord[$] = '{0};
    present(32'h100, 32'h200, 1, 2, 3, 4, 3, 4'b0111);
    collect_spawns("mid", 3, 32'h100, 4'b0111, 0);
    send_done(1);
    step();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({core_ready, spawn_valid, cta_done} !== 3'b000) begin
        n_fail++;
        $display("FAIL mid_reset_c%0d got=%b exp=000", c, {core_ready, spawn_valid, cta_done});
      end
      step();
    end
    check_csr("mid_reset");
    pulse_start();
    present(32'h300, 32'h400, 5, 6, 7, 8, 1, 4'b0001);
    collect_spawns("mid_after", 1, 32'h300, 4'b0001, 0);
    retire("mid_after", ord);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_err();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
